// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down modulo counter with parallel load, terminal count and wrap strobe.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the bounds instead of wrapping.
module updown_counter_param #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             MOD,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, d_in_range, tc;

  always_comb begin
    at_max     = (q_q == MAX_VAL);
    at_zero    = (q_q == '0);
    d_in_range = ({1'b0, D} < MOD_EXT);
    tc         = EN & ((MOD & at_max) | (~MOD & at_zero));
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (LOAD) begin
      q_d = d_in_range ? D : MAX_VAL;
    end else if (EN) begin
`ifdef UPDOWN_COUNTER_SAT_EN
      if (!tc) begin
        q_d = MOD ? (q_q + ONE) : (q_q - ONE);
      end
`else
      if (MOD) begin
        q_d = at_max ? '0 : (q_q + ONE);
      end else begin
        q_d = at_zero ? MAX_VAL : (q_q - ONE);
      end
      wrap_d = tc;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign TC   = tc;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: two standalone instances (mod 8 / mod 6) and a mod-4 cascade pair.
module tb_updown_counter_param;

  localparam int EW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=3, MODULUS=8, RESET_VAL=5
  logic       clr_a = 1'b1, en_a = 1'b0, mod_a = 1'b1, load_a = 1'b0;
  logic [2:0] d_a = '0, q_a;
  logic       tc_a, wrap_a;
  // Instance B: WIDTH=3, MODULUS=6, RESET_VAL=0
  logic       clr_b = 1'b1, en_b = 1'b0, mod_b = 1'b1, load_b = 1'b0;
  logic [2:0] d_b = '0, q_b;
  logic       tc_b, wrap_b;
  // Cascade: two WIDTH=2, MODULUS=4 stages
  logic       clr_c = 1'b1, en_c = 1'b0;
  logic [1:0] q_c0, q_c1;
  logic       tc_c0, tc_c1, wrap_c0, wrap_c1;

  updown_counter_param #(.WIDTH(3), .MODULUS(8), .RESET_VAL(5)) dut_a (
    .CLK(clk), .CLR(clr_a), .EN(en_a), .MOD(mod_a), .LOAD(load_a), .D(d_a),
    .Q(q_a), .TC(tc_a), .WRAP(wrap_a));

  updown_counter_param #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) dut_b (
    .CLK(clk), .CLR(clr_b), .EN(en_b), .MOD(mod_b), .LOAD(load_b), .D(d_b),
    .Q(q_b), .TC(tc_b), .WRAP(wrap_b));

  updown_counter_param #(.WIDTH(2), .MODULUS(4), .RESET_VAL(0)) dut_c0 (
    .CLK(clk), .CLR(clr_c), .EN(en_c), .MOD(1'b1), .LOAD(1'b0), .D(2'b00),
    .Q(q_c0), .TC(tc_c0), .WRAP(wrap_c0));

  updown_counter_param #(.WIDTH(2), .MODULUS(4), .RESET_VAL(0)) dut_c1 (
    .CLK(clk), .CLR(clr_c), .EN(tc_c0), .MOD(1'b1), .LOAD(1'b0), .D(2'b00),
    .Q(q_c1), .TC(tc_c1), .WRAP(wrap_c1));

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model state per standalone instance
  int mq[2];
  bit mvalid[2];
  int mmodv[2] = '{8, 6};
  int mrstv[2] = '{5, 0};
  int ccnt;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on instance sel; expected {WRAP,Q} queued at drive, popped after the edge.
  task automatic step(input int sel, input bit clr, input bit load, input bit en,
                      input bit mod, input int d);
    int nq;
    bit tc, wr;
    logic tc_obs;
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    @(negedge clk);
    if (sel == 0) begin
      clr_a = clr; load_a = load; en_a = en; mod_a = mod; d_a = 3'(d);
    end else begin
      clr_b = clr; load_b = load; en_b = en; mod_b = mod; d_b = 3'(d);
    end
    #1;
    tc = en && ((mod && mq[sel] == mmodv[sel] - 1) || (!mod && mq[sel] == 0));
    if (mvalid[sel]) begin
      tc_obs = (sel == 0) ? tc_a : tc_b;
      check((sel == 0) ? "tc_a" : "tc_b", {3'b000, tc_obs}, {3'b000, tc});
    end
    nq = mq[sel];
    wr = 1'b0;
    if (!clr) nq = mrstv[sel];
    else if (load) nq = (d < mmodv[sel]) ? d : mmodv[sel] - 1;
    else if (en) begin
`ifdef UPDOWN_COUNTER_SAT_EN
      if (!tc) nq = mod ? nq + 1 : nq - 1;
`else
      if (tc) nq = mod ? 0 : mmodv[sel] - 1;
      else    nq = mod ? nq + 1 : nq - 1;
      wr = tc;
`endif
    end
    mq[sel] = nq;
    mvalid[sel] = 1'b1;
    exp_q.push_back({wr, 3'(nq)});
    @(posedge clk);
    #1;
    obs = (sel == 0) ? {wrap_a, q_a} : {wrap_b, q_b};
    e = exp_q.pop_front();
    check((sel == 0) ? "q_wrap_a" : "q_wrap_b", obs, e);
    // Park the instance so it holds while the other one is exercised.
    if (sel == 0) begin
      clr_a = 1'b1; load_a = 1'b0; en_a = 1'b0;
    end else begin
      clr_b = 1'b1; load_b = 1'b0; en_b = 1'b0;
    end
  endtask

  task automatic step_c(input bit clr, input bit en);
    @(negedge clk);
    clr_c = clr;
    en_c  = en;
    #1;
    if (clr) check("tc_c0", {3'b000, tc_c0}, {3'b000, 1'(en && (ccnt % 4 == 3))});
    if (!clr) ccnt = 0;
    else if (en) ccnt = (ccnt + 1) % 16;
    exp_q.push_back(4'(ccnt));
    @(posedge clk);
    #1;
    check("cascade", {q_c1, q_c0}, exp_q.pop_front());
  endtask

  initial begin
    // Instance A: reset with LOAD/EN high, then count up through natural wrap
    step(0, 0, 1, 1, 1, 2);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 3);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);

    // Instance B: mod-6 up wrap, down wrap, direction flip, clamped load
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1, 7);
    step(1, 1, 1, 0, 1, 6);
    step(1, 1, 1, 0, 0, 5);
    step(1, 1, 0, 1, 1, 0);

    // Random mix across both instances
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end

    // Cascade: reset, 20 counting cycles, then a hold
    ccnt = 0;
    step_c(0, 1);
    for (int i = 0; i < 20; i++) step_c(1, 1);
    for (int i = 0; i < 3; i++) step_c(1, 0);
    step_c(1, 1);

    check("queue_empty", EW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
